// File: rtl/branch_pkg.sv
// Shared encodings for branch resolution: condition codes, flag bit positions, FSM states.
package branch_pkg;

    localparam logic [3:0] COND_EQ = 4'd0;
    localparam logic [3:0] COND_NE = 4'd1;
    localparam logic [3:0] COND_CS = 4'd2;
    localparam logic [3:0] COND_CC = 4'd3;
    localparam logic [3:0] COND_MI = 4'd4;
    localparam logic [3:0] COND_PL = 4'd5;
    localparam logic [3:0] COND_VS = 4'd6;
    localparam logic [3:0] COND_VC = 4'd7;
    localparam logic [3:0] COND_HI = 4'd8;
    localparam logic [3:0] COND_LS = 4'd9;
    localparam logic [3:0] COND_GE = 4'd10;
    localparam logic [3:0] COND_LT = 4'd11;
    localparam logic [3:0] COND_GT = 4'd12;
    localparam logic [3:0] COND_LE = 4'd13;
    localparam logic [3:0] COND_AL = 4'd14;
    localparam logic [3:0] COND_NV = 4'd15;

    localparam int unsigned FLG_N = 3;
    localparam int unsigned FLG_Z = 2;
    localparam int unsigned FLG_C = 1;
    localparam int unsigned FLG_V = 0;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_FLUSH = 1'b1;

endpackage

// File: rtl/branch_resolve_if.sv
// Branch request / resolution bus between requester (master) and branch_resolve (slave).
interface branch_resolve_if #(
    parameter int unsigned AW    = 32,
    parameter int unsigned CNT_W = 16
);
    logic [3:0]       flag_in;
    logic             flag_we;
    logic             br_valid;
    logic             br_ready;
    logic [3:0]       br_cond;
    logic [AW-1:0]    br_pc;
    logic [AW-1:0]    br_offset;
    logic             out_valid;
    logic             out_ready;
    logic             out_taken;
    logic [AW-1:0]    out_target;
    logic             flush;
    logic [3:0]       flags_q;
    logic [CNT_W-1:0] br_cnt;
    logic [CNT_W-1:0] taken_cnt;

    modport master (
        output flag_in, flag_we, br_valid, br_cond, br_pc, br_offset, out_ready,
        input  br_ready, out_valid, out_taken, out_target, flush, flags_q, br_cnt, taken_cnt
    );

    modport slave (
        input  flag_in, flag_we, br_valid, br_cond, br_pc, br_offset, out_ready,
        output br_ready, out_valid, out_taken, out_target, flush, flags_q, br_cnt, taken_cnt
    );
endinterface

// File: rtl/cond_eval.sv
// Combinational condition-code evaluation against an {N,Z,C,V} flag vector.
module cond_eval
    import branch_pkg::*;
(
    input  logic [3:0] i_flags,
    input  logic [3:0] i_cond,
    output logic       o_taken
);

    logic w_n, w_z, w_c, w_v;

    assign w_n = i_flags[FLG_N];
    assign w_z = i_flags[FLG_Z];
    assign w_c = i_flags[FLG_C];
    assign w_v = i_flags[FLG_V];

    always_comb begin
        o_taken = 1'b0;
        case (i_cond)
            COND_EQ: o_taken = w_z;
            COND_NE: o_taken = ~w_z;
            COND_CS: o_taken = w_c;
            COND_CC: o_taken = ~w_c;
            COND_MI: o_taken = w_n;
            COND_PL: o_taken = ~w_n;
            COND_VS: o_taken = w_v;
            COND_VC: o_taken = ~w_v;
            COND_HI: o_taken = w_c & ~w_z;
            COND_LS: o_taken = ~w_c | w_z;
            COND_GE: o_taken = (w_n == w_v);
            COND_LT: o_taken = (w_n != w_v);
            COND_GT: o_taken = ~w_z & (w_n == w_v);
            COND_LE: o_taken = w_z | (w_n != w_v);
            COND_AL: o_taken = 1'b1;
            COND_NV: o_taken = 1'b0;
            default: o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve.sv
// Flag register + conditional branch resolution with a one-entry output register,
// post-taken flush sequencer and saturating branch statistics.
module branch_resolve
    import branch_pkg::*;
#(
    parameter int unsigned AW           = 32,
    parameter int unsigned OFF_SHIFT    = 2,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic            clk,
    input  logic            rst,
    branch_resolve_if.slave bus
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

    logic [0:0]       r_state, w_state_nxt;
    logic [3:0]       r_cnt, w_cnt_nxt;
    logic [3:0]       r_flags;
    logic             r_out_valid;
    logic             r_out_taken;
    logic [AW-1:0]    r_out_target;
    logic [CNT_W-1:0] r_br_cnt;
    logic [CNT_W-1:0] r_taken_cnt;

    logic [3:0]       w_flags;
    logic             w_taken;
    logic             w_br_ready;
    logic             w_accept;
    logic [AW-1:0]    w_off_sh;
    logic [AW-1:0]    w_target;

    // Same-cycle flag write is forwarded so a dependent branch sees fresh flags.
    assign w_flags    = bus.flag_we ? bus.flag_in : r_flags;
    assign w_br_ready = (r_state == ST_IDLE) & (~r_out_valid | bus.out_ready);
    assign w_accept   = bus.br_valid & w_br_ready;
    assign w_off_sh   = bus.br_offset << OFF_SHIFT;
    assign w_target   = w_taken ? (bus.br_pc + w_off_sh) : (bus.br_pc + AW'(4));

    cond_eval u_cond_eval (
        .i_flags (w_flags),
        .i_cond  (bus.br_cond),
        .o_taken (w_taken)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_accept && w_taken) begin
                    w_state_nxt = ST_FLUSH;
                    w_cnt_nxt   = FLUSH_INIT;
                end
            end
            ST_FLUSH: begin
                if (r_cnt == 4'd0) w_state_nxt = ST_IDLE;
                else               w_cnt_nxt   = r_cnt - 4'd1;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= 4'd0;
        end else if (bus.flag_we) begin
            r_flags <= bus.flag_in;
        end
    end

    // Output register: replace on accept, clear on pop, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid  <= 1'b0;
            r_out_taken  <= 1'b0;
            r_out_target <= '0;
        end else if (w_accept) begin
            r_out_valid  <= 1'b1;
            r_out_taken  <= w_taken;
            r_out_target <= w_target;
        end else if (r_out_valid && bus.out_ready) begin
            r_out_valid  <= 1'b0;
            r_out_taken  <= 1'b0;
            r_out_target <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_br_cnt    <= '0;
            r_taken_cnt <= '0;
        end else if (w_accept) begin
            if (r_br_cnt != '1)               r_br_cnt    <= r_br_cnt + CNT_W'(1);
            if (w_taken && r_taken_cnt != '1) r_taken_cnt <= r_taken_cnt + CNT_W'(1);
        end
    end

    assign bus.br_ready   = w_br_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_taken  = r_out_taken;
    assign bus.out_target = r_out_target;
    assign bus.flush      = (r_state == ST_FLUSH);
    assign bus.flags_q    = r_flags;
    assign bus.br_cnt     = r_br_cnt;
    assign bus.taken_cnt  = r_taken_cnt;

endmodule

// File: tb/tb_branch_resolve.sv
// Directed vector table, full condition sweep and multi-cycle corner sequences for branch_resolve.
module tb_branch_resolve;

    logic clk;
    logic rst;

    int unsigned n_tests;
    int unsigned n_fail;
    int unsigned exp_br;
    int unsigned exp_tk;

    branch_resolve_if #(.AW(32), .CNT_W(16)) bus ();

    branch_resolve #(
        .AW(32), .OFF_SHIFT(2), .FLUSH_CYCLES(2), .CNT_W(16)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  flags;
        logic        we_same;
        logic [3:0]  cond;
        logic [31:0] pc;
        logic [31:0] off;
        logic        exp_taken;
        logic [31:0] exp_target;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic model_taken(input logic [3:0] f, input logic [3:0] c);
        logic n, z, cy, v;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_flags(input logic [3:0] f);
        bus.flag_we = 1'b1;
        bus.flag_in = f;
        step();
        bus.flag_we = 1'b0;
    endtask

    // Present a branch, wait (bounded) for br_ready, return one cycle after acceptance.
    task automatic accept_br(input logic [3:0] cond, input logic [31:0] pc, input logic [31:0] off,
                             input logic we, input logic [3:0] fin, input logic exp_t);
        int n;
        bus.br_valid  = 1'b1;
        bus.br_cond   = cond;
        bus.br_pc     = pc;
        bus.br_offset = off;
        bus.flag_we   = we;
        bus.flag_in   = fin;
        n = 0;
        while (!bus.br_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) chk("br_ready_timeout", 32'(bus.br_ready), 32'd1);
        step();
        bus.br_valid = 1'b0;
        bus.flag_we  = 1'b0;
        exp_br++;
        if (exp_t) exp_tk++;
    endtask

    initial begin
        n_tests = 0; n_fail = 0; exp_br = 0; exp_tk = 0;
        rst = 1'b1;
        bus.flag_in = 4'd0; bus.flag_we = 1'b0; bus.br_valid = 1'b0;
        bus.br_cond = 4'd0; bus.br_pc = '0; bus.br_offset = '0; bus.out_ready = 1'b1;

        vecs[0] = '{4'b0000, 1'b1, 4'd0,  32'h0000_0100, 32'h0000_0010, 1'b0, 32'h0000_0104};
        vecs[1] = '{4'b1001, 1'b0, 4'd10, 32'h0000_2000, 32'hFFFF_FFFC, 1'b1, 32'h0000_1FF0};
        vecs[2] = '{4'b1000, 1'b0, 4'd11, 32'h0000_0010, 32'h0000_0003, 1'b1, 32'h0000_001C};
        vecs[3] = '{4'b0110, 1'b1, 4'd8,  32'h0000_0040, 32'h0000_0008, 1'b0, 32'h0000_0044};
        vecs[4] = '{4'b0010, 1'b1, 4'd8,  32'h0000_0040, 32'h0000_0008, 1'b1, 32'h0000_0060};
        vecs[5] = '{4'b0000, 1'b0, 4'd14, 32'hFFFF_FFFC, 32'h0000_0001, 1'b1, 32'h0000_0000};
        vecs[6] = '{4'b0000, 1'b0, 4'd14, 32'h0000_1000, 32'hFFFF_FFFF, 1'b1, 32'h0000_0FFC};
        vecs[7] = '{4'b1111, 1'b0, 4'd15, 32'hFFFF_FFFC, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[8] = '{4'b0001, 1'b1, 4'd12, 32'h0000_0500, 32'h0000_0001, 1'b0, 32'h0000_0504};
        vecs[9] = '{4'b0100, 1'b1, 4'd13, 32'h0000_0500, 32'h4000_0001, 1'b1, 32'h0000_0504};

        step();
        step();
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_out_taken", 32'(bus.out_taken), 32'd0);
        chk("rst_out_target", bus.out_target, 32'd0);
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_flags", 32'(bus.flags_q), 32'd0);
        chk("rst_br_cnt", 32'(bus.br_cnt), 32'd0);
        chk("rst_br_ready", 32'(bus.br_ready), 32'd1);
        rst = 1'b0;
        step();

        // BEQ taken with flush timing
        write_flags(4'b0100);
        accept_br(4'd0, 32'h100, 32'h10, 1'b0, 4'd0, 1'b1);
        chk("beq_valid", 32'(bus.out_valid), 32'd1);
        chk("beq_taken", 32'(bus.out_taken), 32'd1);
        chk("beq_target", bus.out_target, 32'h140);
        chk("beq_flush1", 32'(bus.flush), 32'd1);
        chk("beq_ready_in_flush", 32'(bus.br_ready), 32'd0);
        step();
        chk("beq_flush2", 32'(bus.flush), 32'd1);
        chk("beq_popped", 32'(bus.out_valid), 32'd0);
        step();
        chk("beq_flush_end", 32'(bus.flush), 32'd0);
        chk("beq_ready_after", 32'(bus.br_ready), 32'd1);

        // Directed vector table
        for (int i = 0; i < 10; i++) begin
            if (!vecs[i].we_same) write_flags(vecs[i].flags);
            accept_br(vecs[i].cond, vecs[i].pc, vecs[i].off, vecs[i].we_same, vecs[i].flags,
                      vecs[i].exp_taken);
            chk($sformatf("vec%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("vec%0d_taken", i), 32'(bus.out_taken), 32'(vecs[i].exp_taken));
            chk($sformatf("vec%0d_target", i), bus.out_target, vecs[i].exp_target);
            chk($sformatf("vec%0d_flush", i), 32'(bus.flush), 32'(vecs[i].exp_taken));
            chk($sformatf("vec%0d_flags", i), 32'(bus.flags_q), 32'(vecs[i].flags));
        end

        // Full condition x flags sweep
        for (int f = 0; f < 16; f++) begin
            for (int c = 0; c < 16; c++) begin
                logic et;
                et = model_taken(4'(f), 4'(c));
                write_flags(4'(f));
                accept_br(4'(c), 32'h1000, 32'h4, 1'b0, 4'd0, et);
                chk($sformatf("sweep_f%0d_c%0d_taken", f, c), 32'(bus.out_taken), 32'(et));
                chk($sformatf("sweep_f%0d_c%0d_target", f, c), bus.out_target,
                    et ? 32'h1010 : 32'h1004);
            end
        end

        // Back-pressure: output held, new branch blocked, then pop+accept together
        write_flags(4'b0100);
        bus.out_ready = 1'b0;
        accept_br(4'd0, 32'h200, 32'h8, 1'b0, 4'd0, 1'b1);
        bus.br_valid = 1'b1; bus.br_cond = 4'd1; bus.br_pc = 32'h300; bus.br_offset = 32'h0;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("stall%0d_valid", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("stall%0d_target", i), bus.out_target, 32'h220);
            chk($sformatf("stall%0d_taken", i), 32'(bus.out_taken), 32'd1);
            chk($sformatf("stall%0d_br_ready", i), 32'(bus.br_ready), 32'd0);
            step();
        end
        bus.out_ready = 1'b1;
        #1;
        chk("release_br_ready", 32'(bus.br_ready), 32'd1);
        step();
        bus.br_valid = 1'b0;
        exp_br++;
        chk("replace_valid", 32'(bus.out_valid), 32'd1);
        chk("replace_taken", 32'(bus.out_taken), 32'd0);
        chk("replace_target", bus.out_target, 32'h304);
        step();
        chk("replace_popped", 32'(bus.out_valid), 32'd0);

        chk("br_cnt", 32'(bus.br_cnt), exp_br);
        chk("taken_cnt", 32'(bus.taken_cnt), exp_tk);

        // Reset during second flush cycle with a pending output
        write_flags(4'b0100);
        bus.out_ready = 1'b0;
        accept_br(4'd0, 32'h0, 32'h1, 1'b0, 4'd0, 1'b1);
        step();
        chk("mid_flush2", 32'(bus.flush), 32'd1);
        chk("mid_pending", 32'(bus.out_valid), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_flush", 32'(bus.flush), 32'd0);
        chk("rst2_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst2_br_cnt", 32'(bus.br_cnt), 32'd0);
        chk("rst2_taken_cnt", 32'(bus.taken_cnt), 32'd0);
        chk("rst2_flags", 32'(bus.flags_q), 32'd0);
        chk("rst2_br_ready", 32'(bus.br_ready), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
